uart_rx: RTL

- Receive half of the console UART; sits downstream of the RX pad and upstream of the core's memory bus decode at uart_base_addr.
- Samples the asynchronous rx line with the bit period from the configuration package (clks_per_bit) and assembles 8N1 frames.
- Buffers received bytes in a small FIFO.
- Exposes data and status registers through the codebase's valid/ready memory interface.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_if.sv | 13 +
 rtl/uart_rx_fifo.sv | 53 +++++
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared configuration and type definitions for the console UART receiver.
// Holds the bit timing, bus base address, FSM state enum and STATUS bit indices.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_rx_pkg;

  // 25 MHz / 115200 baud, minus one: one bit lasts clks_per_bit+1 cycles
  localparam int unsigned clks_per_bit   = 216;
  localparam int unsigned fifo_depth     = 2;
  localparam logic [31:0] uart_base_addr = 32'h1000_0000;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } rx_state_t;

  localparam int st_nonempty  = 0;
  localparam int st_full      = 1;
  localparam int st_ovr       = 2;
  localparam int st_ferr      = 3;
  localparam int st_perr      = 4;
  localparam int st_count_lsb = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Valid/ready memory-bus slice used by the UART receiver register block.
interface uart_rx_if;
  logic        uart_valid;
  logic [31:0] uart_addr;
  logic [3:0]  uart_wstrb;
  logic        uart_ready;
  logic [31:0] uart_rdata;

  modport master (output uart_valid, uart_addr, uart_wstrb,
                  input  uart_ready, uart_rdata);
  modport slave  (input  uart_valid, uart_addr, uart_wstrb,
                  output uart_ready, uart_rdata);
endinterface

// File: rtl/uart_rx_fifo.sv
// Small byte FIFO for received characters; 2**fifo_depth entries.
// A push while full only lands when a pop frees the slot in the same cycle.
module uart_rx_fifo #(
  parameter int unsigned fifo_depth = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic                  full,
  output logic                  empty,
  output logic [fifo_depth:0]   count
);

  localparam int unsigned entries = 1 << fifo_depth;

  logic [7:0]            mem [entries];
  logic [fifo_depth-1:0] wptr;
  logic [fifo_depth-1:0] rptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (fifo_depth+1)'(entries));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr];

  // Storage array; no reset needed, contents are qualified by count
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Console UART receiver: 2-flop rx synchronizer, frame FSM, RX FIFO and
// DATA/STATUS registers on the valid/ready bus (addr bit 2 selects STATUS).
// Optional feature macro: UART_RX_PARITY_EN (even parity bit before stop).
//
// state  | meaning
// IDLE   | line idle, waiting for a low level
// START  | half a bit in, confirming the start bit
// DATA   | sampling D0..D7 at bit centres, LSB first
// PARITY | sampling the even-parity bit (parity builds only)
// STOP   | sampling the stop bit, pushing the byte if the frame is good
// BREAK  | framing error seen, waiting for the line to return high
module uart_rx #(
  parameter int unsigned clks_per_bit = uart_rx_pkg::clks_per_bit,
  parameter int unsigned fifo_depth   = uart_rx_pkg::fifo_depth
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     rx,
  uart_rx_if.slave bus,
  output logic     rx_irq
);
  import uart_rx_pkg::*;

  localparam int cnt_w = $clog2(clks_per_bit + 1);

  logic               rx_meta, rx_sync;
  rx_state_t          state;
  logic [cnt_w-1:0]   cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shreg;
  logic               push;
  logic [7:0]         push_data;
  logic               ferr_set;
  logic               ovr, ferr, perr;
  logic [7:0]         head;
  logic               full, empty;
  logic [fifo_depth:0] count;
  logic               rd, data_rd, status_rd, pop;
  logic [31:0]        status_word;
  logic               unused_addr_bits;
`ifdef UART_RX_PARITY_EN
  logic               par_bit;
  logic               perr_set;
`endif

  assign unused_addr_bits = ^{bus.uart_addr[31:3], bus.uart_addr[1:0]};

  // Bring the asynchronous line into the clock domain; idles high
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Frame FSM with registered push and error pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push      <= 1'b0;
      push_data <= '0;
      ferr_set  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit   <= 1'b0;
      perr_set  <= 1'b0;
`endif
    end else begin
      push     <= 1'b0;
      ferr_set <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_set <= 1'b0;
`endif
      if (state != IDLE && state != BREAK && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        case (state)
          IDLE: if (!rx_sync) begin
            state <= START;
            cnt   <= cnt_w'(clks_per_bit / 2);
          end
          START: begin
            if (!rx_sync) begin
              state   <= DATA;
              bit_idx <= '0;
              cnt     <= cnt_w'(clks_per_bit);
            end else begin
              state <= IDLE;
            end
          end
          DATA: begin
            shreg[bit_idx] <= rx_sync;
            cnt            <= cnt_w'(clks_per_bit);
            bit_idx        <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= PARITY;
`else
            if (bit_idx == 3'd7) state <= STOP;
`endif
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            par_bit <= rx_sync;
            cnt     <= cnt_w'(clks_per_bit);
            state   <= STOP;
          end
`endif
          STOP: begin
`ifdef UART_RX_PARITY_EN
            perr_set <= (^shreg) != par_bit;
            push     <= rx_sync && ((^shreg) == par_bit);
`else
            push     <= rx_sync;
`endif
            push_data <= shreg;
            ferr_set  <= !rx_sync;
            state     <= rx_sync ? IDLE : BREAK;
          end
          BREAK: if (rx_sync) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  uart_rx_fifo #(.fifo_depth(fifo_depth)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign rd        = bus.uart_valid && (bus.uart_wstrb == 4'b0000);
  assign data_rd   = rd && !bus.uart_addr[2];
  assign status_rd = rd &&  bus.uart_addr[2];
  assign pop       = data_rd && !empty;
  assign rx_irq    = !empty;

  // Sticky error flags: clear on STATUS read, a same-cycle set wins
  always_ff @(posedge clock) begin
    if (reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      ovr  <= (push && full && !pop) || (ovr  && !status_rd);
      ferr <= ferr_set               || (ferr && !status_rd);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity error sticky flag, same clear-on-read rule
  always_ff @(posedge clock) begin
    if (reset) perr <= 1'b0;
    else       perr <= perr_set || (perr && !status_rd);
  end
`else
  assign perr = 1'b0;
`endif

  // Assemble the STATUS register view
  always_comb begin
    status_word                                  = '0;
    status_word[st_nonempty]                     = !empty;
    status_word[st_full]                         = full;
    status_word[st_ovr]                          = ovr;
    status_word[st_ferr]                         = ferr;
    status_word[st_perr]                         = perr;
    status_word[st_count_lsb +: fifo_depth + 1]  = count;
  end

  // One-cycle acknowledge; read data is forced to zero outside the ack
  always_ff @(posedge clock) begin
    if (reset) begin
      bus.uart_ready <= 1'b0;
      bus.uart_rdata <= '0;
    end else begin
      bus.uart_ready <= bus.uart_valid;
      if (data_rd)        bus.uart_rdata <= {23'd0, !empty, empty ? 8'h00 : head};
      else if (status_rd) bus.uart_rdata <= status_word;
      else                bus.uart_rdata <= '0;
    end
  end

endmodule
